// File: rtl/addition_kernel_seq.sv
// rtl/addition_kernel_seq.sv - job sequencer streaming paired source blocks through the 8-lane adder kernel
module addition_kernel_seq #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int CW    = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [AW-1:0]       src1_base,
  input  logic [AW-1:0]       src2_base,
  input  logic [AW-1:0]       dst_base,
  input  logic [CW-1:0]       num_blocks,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr1,
  output logic [AW-1:0]       rd_addr2,
  input  logic [LANES*DW-1:0] rd_data1,
  input  logic [LANES*DW-1:0] rd_data2,
  output logic [LANES*DW-1:0] k_in1,
  output logic [LANES*DW-1:0] k_in2,
  input  logic [LANES*DW-1:0] k_out,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [LANES*DW-1:0] wr_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [1:0]    state;
  logic [CW-1:0] num_lat;
  logic [CW-1:0] issue_cnt;
  logic [AW-1:0] dst_addr;
  logic          v1, v2;
  logic [AW-1:0] d1, d2;

  assign k_in1   = rd_data1;
  assign k_in2   = rd_data2;
  assign wr_data = k_out;
  assign wr_en   = v2;
  assign wr_addr = d2;
  assign busy    = (state == S_ISSUE) || (state == S_DRAIN);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      num_lat   <= '0;
      issue_cnt <= '0;
      dst_addr  <= '0;
      rd_en     <= 1'b0;
      rd_addr1  <= '0;
      rd_addr2  <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      d1        <= '0;
      d2        <= '0;
    end else begin
      // Valid and destination tags follow the read by one and two cycles
      v1 <= rd_en;
      v2 <= v1;
      d1 <= dst_addr;
      d2 <= d1;

      case (state)
        S_IDLE: begin
          if (start) begin
            num_lat <= num_blocks;
            if (num_blocks == '0) begin
              state <= S_DONE;
            end else begin
              state     <= S_ISSUE;
              rd_en     <= 1'b1;
              rd_addr1  <= src1_base;
              rd_addr2  <= src2_base;
              dst_addr  <= dst_base;
              issue_cnt <= CNT_ONE;
            end
          end
        end
        S_ISSUE: begin
          if (issue_cnt == num_lat) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end else begin
            issue_cnt <= issue_cnt + CNT_ONE;
            rd_addr1  <= rd_addr1 + ADDR_ONE;
            rd_addr2  <= rd_addr2 + ADDR_ONE;
            dst_addr  <= dst_addr + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          // With reads stopped, v1 low now means both stages are empty next cycle
          if (!v1) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      if (abort && busy) begin
        state <= S_IDLE;
        rd_en <= 1'b0;
        v1    <= 1'b0;
        v2    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addition_kernel_seq.sv
// tb/tb_addition_kernel_seq.sv - scoreboard bench for addition_kernel_seq with memory and kernel models
module tb_addition_kernel_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [7:0]  src1_base, src2_base, dst_base;
  logic [8:0]  num_blocks;
  logic        busy, done, rd_en, wr_en;
  logic [7:0]  rd_addr1, rd_addr2, wr_addr;
  logic [63:0] rd_data1, rd_data2, k_in1, k_in2, k_out, wr_data;

  logic [63:0] mem1 [256];
  logic [63:0] mem2 [256];

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addition_kernel_seq #(.LANES(8), .DW(8), .AW(8), .CW(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src1_base(src1_base), .src2_base(src2_base), .dst_base(dst_base),
    .num_blocks(num_blocks), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .k_in1(k_in1), .k_in2(k_in2), .k_out(k_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
    return r;
  endfunction

  // Synchronous source memories and the registered kernel
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data1 <= mem1[rd_addr1];
      rd_data2 <= mem2[rd_addr2];
    end
    k_out <= lane_add(k_in1, k_in2);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_job(input string name, input logic [7:0] s1, input logic [7:0] s2,
                         input logic [7:0] d, input logic [8:0] n, input int abort_at);
    int   done_cyc, last;
    exp_t e, got;
    logic exp_rd, exp_busy, exp_done;
    done_cyc = (n == 0) ? 1 : int'(n) + 3;
    last     = (abort_at >= 0) ? abort_at : done_cyc + 1;
    for (int k = 0; k < int'(n); k++) begin
      if (abort_at < 0 || k + 3 <= abort_at) begin
        e.cyc  = k + 3;
        e.addr = 8'(int'(d) + k);
        e.data = lane_add(mem1[8'(int'(s1) + k)], mem2[8'(int'(s2) + k)]);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_before_start: busy=%b done=%b wr_en=%b rd_en=%b want all 0",
               name, busy, done, wr_en, rd_en);
    end
    abort = 1'b0; src1_base = s1; src2_base = s2; dst_base = d; num_blocks = n; start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start    = 1'b0;
      exp_rd   = (c <= int'(n));
      exp_busy = (n != 0) && (c <= int'(n) + 2);
      exp_done = (c == done_cyc);
      checks++;
      if (rd_en !== exp_rd) begin
        errors++;
        $display("FAIL %s rd_en cyc %0d: got %b want %b", name, c, rd_en, exp_rd);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy cyc %0d: got %b want %b", name, c, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL %s done cyc %0d: got %b want %b", name, c, done, exp_done);
      end
      if (exp_rd) begin
        checks++;
        if (rd_addr1 !== 8'(int'(s1) + c - 1) || rd_addr2 !== 8'(int'(s2) + c - 1)) begin
          errors++;
          $display("FAIL %s rd_addr cyc %0d: got %h/%h want %h/%h", name, c, rd_addr1, rd_addr2,
                   8'(int'(s1) + c - 1), 8'(int'(s2) + c - 1));
        end
      end
      if (c >= 2 && c <= int'(n) + 1) begin
        checks++;
        if (k_in1 !== mem1[8'(int'(s1) + c - 2)] || k_in2 !== mem2[8'(int'(s2) + c - 2)]) begin
          errors++;
          $display("FAIL %s k_in cyc %0d: got %h/%h want %h/%h", name, c, k_in1, k_in2,
                   mem1[8'(int'(s1) + c - 2)], mem2[8'(int'(s2) + c - 2)]);
        end
      end
      if (wr_en === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_wr cyc %0d: got wr_en=1 addr %h want no write", name, c, wr_addr);
        end else begin
          got = sb.pop_front();
          if (got.cyc != c || wr_addr !== got.addr || wr_data !== got.data) begin
            errors++;
            $display("FAIL %s write cyc %0d: got addr %h data %h want cyc %0d addr %h data %h",
                     name, c, wr_addr, wr_data, got.cyc, got.addr, got.data);
          end
        end
      end
      if (c == abort_at) abort = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_writes: got %0d outstanding want 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src1_base = '0; src2_base = '0; dst_base = '0; num_blocks = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'b0000 || rd_addr1 !== 8'h00 || rd_addr2 !== 8'h00 ||
        wr_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b rd_en=%b wr_en=%b addr %h/%h/%h want all 0",
               busy, done, rd_en, wr_en, rd_addr1, rd_addr2, wr_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    mem1[8'h10] = 64'd200;
    mem2[8'h20] = 64'd100;
    run_job("single", 8'h10, 8'h20, 8'h30, 9'd1, -1);
  endtask

  task automatic test_lanes();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        mem1[8'(8'h40 + b)][i*8 +: 8] = 8'(i);
        mem2[8'(8'h50 + b)][i*8 +: 8] = 8'(2 * i);
      end
    end
    run_job("lanes", 8'h40, 8'h50, 8'h60, 9'd4, -1);
  endtask

  task automatic test_wrap();
    run_job("wrap", 8'hFE, 8'h7E, 8'hFE, 9'd3, -1);
  endtask

  task automatic test_zero();
    run_job("zero", 8'h01, 8'h02, 8'h03, 9'd0, -1);
  endtask

  task automatic test_abort();
    run_job("abort", 8'h80, 8'h90, 8'hA0, 9'd8, 4);
    run_job("after_abort", 8'h05, 8'h06, 8'h07, 9'd2, -1);
  endtask

  task automatic test_back_to_back();
    run_job("b2b", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 9'd20, -1);
    run_job("b2b_next", 8'hF0, 8'hF8, 8'hF4, 9'd17, -1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    src1_base = 8'h40; src2_base = 8'h50; dst_base = 8'h60; num_blocks = 9'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    src1_base = 8'h80; num_blocks = 9'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (rd_addr1 !== 8'h42 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored: got rd_addr1 %h busy %b want 42 1", rd_addr1, busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'b0000 || rd_addr1 !== 8'h00 || rd_addr2 !== 8'h00 ||
        wr_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b done=%b rd_en=%b wr_en=%b addr %h/%h/%h want all 0",
               busy, done, rd_en, wr_en, rd_addr1, rd_addr2, wr_addr);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet cyc %0d: got wr_en=%b done=%b rd_en=%b want 0", c, wr_en, done, rd_en);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = {$urandom, $urandom};
      mem2[i] = {$urandom, $urandom};
    end
    test_reset();
    test_single();
    test_lanes();
    test_wrap();
    test_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    run_job("post_reset", 8'h11, 8'h22, 8'h33, 9'd5, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addition_kernel_seq.md
Name: addition_kernel_seq

Overview:
Sequencer that streams a job of packed 8-lane operand blocks through the registered 8-lane addition kernel. It issues paired reads from two source memory regions and presents the read data to the kernel lanes. It tracks the kernel's one-cycle latency and writes each sum block back to a destination region, with a start/busy/done job handshake. Throughput is one block per cycle; there is no backpressure.

Parameters:
LANES, 8, number of adder lanes (kernel width)
DW, 8, bits per lane
AW, 8, block address width (one address = one packed LANES*DW word)
CW, 9, width of block-count field

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
start  input  1  launch job; sampled only in IDLE
abort  input  1  cancel running job
src1_base  input  AW  first block address, operand 1
src2_base  input  AW  first block address, operand 2
dst_base  input  AW  first block address, results
num_blocks  input  CW  blocks in job
busy  output  1  high from accepted start until done/abort
done  output  1  one-cycle pulse after last write
rd_en  output  1  read strobe, both source ports
rd_addr1  output  AW  operand-1 read address
rd_addr2  output  AW  operand-2 read address
rd_data1  input  LANES*DW  operand-1 data, valid 1 cycle after rd_en
rd_data2  input  LANES*DW  operand-2 data, valid 1 cycle after rd_en
k_in1  output  LANES*DW  to kernel input1 lanes; lane i = bits [i*DW +: DW]
k_in2  output  LANES*DW  to kernel input2 lanes
k_out  input  LANES*DW  kernel outputs, registered 1 cycle after k_in
wr_en  output  1  result write strobe
wr_addr  output  AW  result block address
wr_data  output  LANES*DW  result block (= k_out)

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; busy, done, rd_en, wr_en = 0; rd_addr*, wr_addr = 0; pipeline valid bits and counters cleared. Reset mid-job drops the job; no write or done follows.
- k_in1 = rd_data1, k_in2 = rd_data2 (combinational pass-through); wr_data = k_out.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches bases and num_blocks; busy=1 next cycle.
  - num_blocks=0 -> DONE directly, no reads or writes.
  - Otherwise -> ISSUE.
- ISSUE: rd_en=1 every cycle. Block k uses rd_addr1=src1_base+k and rd_addr2=src2_base+k, mod 2^AW (wrap). After num_blocks issues -> DRAIN.
- Pipeline: read issued at cycle t; data and kernel inputs valid at t+1; kernel output and wr_en at t+2 with wr_addr=dst_base+k mod 2^AW. Valid and dst-address tags shift in two stages: v1, v2; wr_en=v2.
- DRAIN: rd_en=0; wait until v1=v2=0 -> DONE.
- DONE: done=1 for one cycle; busy=0 on the same cycle; -> IDLE.
- Latency: start at cycle 0 -> first rd_en at cycle 1 -> first wr_en at cycle 3. Last wr_en at cycle num_blocks+2; done at cycle num_blocks+3.
- start while busy: ignored, with no effect on the latched job.
- abort while busy (priority over everything except reset):
  - Next cycle: rd_en=0, v1/v2 cleared so no further wr_en, state IDLE, busy=0, done not pulsed.
  - An abort coinciding with start in IDLE: start is taken, abort ignored.
- Arithmetic belongs to the kernel: per-lane DW-bit wrap, no carry between lanes. The sequencer never alters data.
- Overlapping src/dst regions are legal; reads always precede the write of the same block by two cycles.

Test Plan:
- num_blocks=1, src1_base=0x10, src2_base=0x20, dst_base=0x30; lane0 200+100 -> wr_en at cycle 3, wr_addr=0x30, lane0 sum=44; done at cycle 4.
- num_blocks=4, lanes i: op1=i, op2=2i -> back-to-back wr_en cycles 3..6 at dst..dst+3, each lane = 3i; done at cycle 7; busy high cycles 1..6.
- src1_base=0xFE, num_blocks=3 -> rd_addr1 sequence 0xFE, 0xFF, 0x00; same wrap on wr_addr.
- num_blocks=0 -> done pulse one cycle after start; rd_en and wr_en never asserted.
- num_blocks=8, abort at cycle 4 -> writes only for blocks issued before abort whose wr_en falls at or before cycle 4; no wr_en after cycle 4; done never asserted; a new start is accepted next cycle.
- rst_n=0 for one cycle mid-ISSUE; start pulsed again during the job -> all outputs 0 after reset; the re-pulsed start is ignored while busy.
